pdm_codec_subsystem: RTL and testbench

Stereo audio PDM codec plus IR pulse-density receiver, all in the `clk` domain. It holds three sub-blocks:
- a stereo audio PDM modulator (two 32-bit words to one interleaved 1-bit stream);
- a stereo audio PDM demodulator (1-bit stream to two 32-bit words);
- an IR PDM demodulator that recovers a 5-bit value from a carrier-keyed slot frame.

It sits between the audio/IR register interface and the PDM pins. `ock`/`bck` pins are asynchronous to `clk` and are oversampled.

---
 rtl/pdm_codec_subsystem_if.sv | 36 +++
 rtl/pdm_codec_subsystem.sv | 196 +++++++++++++++++++
 tb/tb_pdm_codec_subsystem.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_codec_subsystem_if.sv
// Register-side and pin-side signals of the PDM codec subsystem.
// master owns samples, configuration and input pins; slave is the codec.
interface pdm_codec_subsystem_if;
    logic [5:0]  mod_scale;
    logic [31:0] mod_align;
    logic [31:0] mod_din_l;
    logic [31:0] mod_din_r;
    logic        mod_ock;
    logic        mod_sdo;
    logic [5:0]  demod_scale;
    logic [31:0] demod_align;
    logic        demod_sdi;
    logic        demod_ock;
    logic [31:0] demod_dout_l;
    logic [31:0] demod_dout_r;
    logic        ir_sdi;
    logic        ir_ock;
    logic        ir_bck;
    logic        ir_load;
    logic        ir_done;
    logic [4:0]  ir_dout;

    modport master (
        output mod_scale, mod_align, mod_din_l, mod_din_r, mod_ock,
        output demod_scale, demod_align, demod_sdi, demod_ock,
        output ir_sdi, ir_ock, ir_bck, ir_load,
        input  mod_sdo, demod_dout_l, demod_dout_r, ir_done, ir_dout
    );

    modport slave (
        input  mod_scale, mod_align, mod_din_l, mod_din_r, mod_ock,
        input  demod_scale, demod_align, demod_sdi, demod_ock,
        input  ir_sdi, ir_ock, ir_bck, ir_load,
        output mod_sdo, demod_dout_l, demod_dout_r, ir_done, ir_dout
    );
endinterface

// File: rtl/pdm_codec_subsystem.sv
// Stereo PDM modulator/demodulator plus IR slot-frame receiver on oversampled pins.
// Latency: strobes 3 clk after a pin edge, mod_sdo 4 clk, demod outputs 5 clk; no backpressure.
module pdm_codec_subsystem #(
    parameter int FILTER_SHIFT  = 5,
    parameter int IR_SLOTS      = 31,
    parameter int IR_MIN_PULSES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    pdm_codec_subsystem_if.slave  bus
);
    localparam int CK_MOD   = 0;
    localparam int CK_DEMOD = 1;
    localparam int CK_IR    = 2;
    localparam int CK_BCK   = 3;
    localparam int SLOT_W   = $clog2(IR_SLOTS);

    function automatic logic [31:0] scale_fn(input logic [31:0] x,
                                             input logic [5:0]  scale,
                                             input logic [31:0] align);
        logic [31:0] shifted;
        shifted = scale[5] ? (x >> scale[4:0]) : (x << scale[4:0]);
        return shifted + align;
    endfunction

    // One-pole IIR towards full-scale or zero; d is kept 34-bit signed so the
    // arithmetic shift rounds toward minus infinity for falling steps.
    function automatic logic [31:0] iir_step(input logic [31:0] y, input logic bit_in);
        logic signed [33:0] d;
        logic signed [33:0] sum;
        d   = $signed({2'b00, {32{bit_in}}}) - $signed({2'b00, y});
        sum = $signed({2'b00, y}) + (d >>> FILTER_SHIFT);
        return sum[31:0];
    endfunction

    // ------------------------------------------------------------------
    // Pin conditioning
    // ------------------------------------------------------------------
    logic [3:0] ck_pin, ck_s1, ck_s2, ck_s3, rise, fall;
    logic [1:0] d_pin, d_s1, d_s2;

    assign ck_pin = {bus.ir_bck, bus.ir_ock, bus.demod_ock, bus.mod_ock};
    assign d_pin  = {bus.ir_sdi, bus.demod_sdi};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ck_s1 <= '0;
            ck_s2 <= '0;
            ck_s3 <= '0;
            rise  <= '0;
            fall  <= '0;
            d_s1  <= '0;
            d_s2  <= '0;
        end else begin
            ck_s1 <= ck_pin;
            ck_s2 <= ck_s1;
            ck_s3 <= ck_s2;
            rise  <= ck_s2 & ~ck_s3;
            fall  <= ~ck_s2 & ck_s3;
            d_s1  <= d_pin;
            d_s2  <= d_s1;
        end
    end

    // ------------------------------------------------------------------
    // Audio modulator: first-order sigma-delta per channel
    // ------------------------------------------------------------------
    logic [31:0] acc_l, acc_r;
    logic        mod_sdo_q;
    logic [32:0] mod_sum_l, mod_sum_r;

    assign mod_sum_l = {1'b0, acc_l} + {1'b0, scale_fn(bus.mod_din_l, bus.mod_scale, bus.mod_align)};
    assign mod_sum_r = {1'b0, acc_r} + {1'b0, scale_fn(bus.mod_din_r, bus.mod_scale, bus.mod_align)};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_l     <= '0;
            acc_r     <= '0;
            mod_sdo_q <= 1'b0;
        end else if (rise[CK_MOD]) begin
            acc_l     <= mod_sum_l[31:0];
            mod_sdo_q <= mod_sum_l[32];
        end else if (fall[CK_MOD]) begin
            acc_r     <= mod_sum_r[31:0];
            mod_sdo_q <= mod_sum_r[32];
        end
    end

    assign bus.mod_sdo = mod_sdo_q;

    // ------------------------------------------------------------------
    // Audio demodulator: left on fall, right on rise
    // ------------------------------------------------------------------
    logic [31:0] y_l, y_r, dout_l, dout_r;
    logic        upd_l, upd_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_l    <= '0;
            y_r    <= '0;
            upd_l  <= 1'b0;
            upd_r  <= 1'b0;
            dout_l <= '0;
            dout_r <= '0;
        end else begin
            upd_l <= fall[CK_DEMOD];
            upd_r <= rise[CK_DEMOD];
            if (fall[CK_DEMOD]) y_l <= iir_step(y_l, d_s2[0]);
            if (rise[CK_DEMOD]) y_r <= iir_step(y_r, d_s2[0]);
            if (upd_l) dout_l <= scale_fn(y_l, bus.demod_scale, bus.demod_align);
            if (upd_r) dout_r <= scale_fn(y_r, bus.demod_scale, bus.demod_align);
        end
    end

    assign bus.demod_dout_l = dout_l;
    assign bus.demod_dout_r = dout_r;

    // ------------------------------------------------------------------
    // IR slot-frame receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IR_IDLE, IR_ARM, IR_RUN} ir_state_t;

    ir_state_t         ir_state, ir_state_nxt;
    logic [SLOT_W-1:0] slot, slot_nxt;
    logic [1:0]        pulses, pulses_nxt, pulses_inc;
    logic [4:0]        count, count_nxt;
    logic [4:0]        ir_dout_q, ir_dout_nxt;
    logic              ir_done_q, ir_done_nxt;
    logic              ir_pulse;

    assign ir_pulse = rise[CK_IR] & d_s2[1];

    always_comb begin
        ir_state_nxt = ir_state;
        slot_nxt     = slot;
        pulses_nxt   = pulses;
        count_nxt    = count;
        ir_dout_nxt  = ir_dout_q;
        ir_done_nxt  = ir_done_q;
        pulses_inc   = (ir_pulse && pulses != 2'd3) ? pulses + 2'd1 : pulses;

        case (ir_state)
            IR_IDLE: begin
                if (bus.ir_load) begin
                    ir_state_nxt = IR_ARM;
                    ir_done_nxt  = 1'b0;
                end
            end
            IR_ARM: begin
                if (rise[CK_BCK]) begin
                    ir_state_nxt = IR_RUN;
                    slot_nxt     = '0;
                    pulses_nxt   = '0;
                    count_nxt    = '0;
                end
            end
            IR_RUN: begin
                pulses_nxt = pulses_inc;
                // A carrier pulse coinciding with the slot clock belongs to the closing slot.
                if (rise[CK_BCK]) begin
                    pulses_nxt = '0;
                    if (int'(pulses_inc) >= IR_MIN_PULSES) count_nxt = count + 5'd1;
                    slot_nxt = slot + SLOT_W'(1);
                    if (int'(slot) == IR_SLOTS - 1) begin
                        ir_dout_nxt  = count_nxt;
                        ir_done_nxt  = 1'b1;
                        ir_state_nxt = IR_IDLE;
                    end
                end
            end
            default: ir_state_nxt = IR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ir_state  <= IR_IDLE;
            slot      <= '0;
            pulses    <= '0;
            count     <= '0;
            ir_dout_q <= '0;
            ir_done_q <= 1'b1;
        end else begin
            ir_state  <= ir_state_nxt;
            slot      <= slot_nxt;
            pulses    <= pulses_nxt;
            count     <= count_nxt;
            ir_dout_q <= ir_dout_nxt;
            ir_done_q <= ir_done_nxt;
        end
    end

    assign bus.ir_done = ir_done_q;
    assign bus.ir_dout = ir_dout_q;

endmodule

// File: tb/tb_pdm_codec_subsystem.sv
// Directed bench for pdm_codec_subsystem: reset, modulator patterns, demod scaling, loopback and IR frames.
module tb_pdm_codec_subsystem;
    localparam int HALF = 8;

    logic clk;
    logic rstn;
    logic loop_en;
    logic sdi_drv;
    logic dock_drv;
    int   vectors;
    int   miscompares;

    pdm_codec_subsystem_if bus ();

    assign bus.demod_sdi = loop_en ? bus.mod_sdo : sdi_drv;
    assign bus.demod_ock = loop_en ? bus.mod_ock : dock_drv;

    pdm_codec_subsystem #(
        .FILTER_SHIFT  (5),
        .IR_SLOTS      (31),
        .IR_MIN_PULSES (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        loop_en         = 1'b0;
        sdi_drv         = 1'b0;
        dock_drv        = 1'b0;
        bus.mod_scale   = '0;
        bus.mod_align   = '0;
        bus.mod_din_l   = '0;
        bus.mod_din_r   = '0;
        bus.mod_ock     = 1'b0;
        bus.demod_scale = '0;
        bus.demod_align = '0;
        bus.ir_sdi      = 1'b0;
        bus.ir_ock      = 1'b0;
        bus.ir_bck      = 1'b0;
        bus.ir_load     = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        bus.mod_din_l = 32'hFFFF_FFFF;
        bus.mod_din_r = 32'hFFFF_FFFF;
        sdi_drv       = 1'b1;
        bus.ir_sdi    = 1'b1;
        bus.ir_load   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.mod_ock = ~bus.mod_ock;
            dock_drv    = ~dock_drv;
            bus.ir_ock  = ~bus.ir_ock;
            bus.ir_bck  = ~bus.ir_bck;
        end
        @(negedge clk);
        vectors++;
        if (bus.mod_sdo !== 1'b0 || bus.ir_done !== 1'b1 || bus.ir_dout !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_hold: sdo=%b done=%b dout=%0d want 0/1/0", bus.mod_sdo, bus.ir_done, bus.ir_dout);
        end
        vectors++;
        if (bus.demod_dout_l !== 32'h0 || bus.demod_dout_r !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_demod: l=%h r=%h want 0/0", bus.demod_dout_l, bus.demod_dout_r);
        end
        clear_inputs();
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        vectors++;
        if (bus.mod_sdo !== 1'b0 || bus.ir_done !== 1'b1 || bus.demod_dout_r !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_release: sdo=%b done=%b r=%h want 0/1/0", bus.mod_sdo, bus.ir_done, bus.demod_dout_r);
        end
        sdi_drv = 1'b1;
        repeat (3) @(negedge clk);
        dock_drv = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (bus.demod_dout_r !== 32'h0) begin
            miscompares++;
            $display("FAIL demod_latency_early: got %h want 00000000", bus.demod_dout_r);
        end
        @(negedge clk);
        vectors++;
        if (bus.demod_dout_r !== 32'h07FF_FFFF || bus.demod_dout_l !== 32'h0) begin
            miscompares++;
            $display("FAIL demod_latency_5clk: r=%h l=%h want 07ffffff/00000000", bus.demod_dout_r, bus.demod_dout_l);
        end
    endtask

    task automatic test_mod_dc();
        logic exp_l;
        do_reset();
        bus.mod_scale = 6'b000000;
        bus.mod_align = 32'h0;
        bus.mod_din_l = 32'h4000_0000;
        bus.mod_din_r = 32'h0;
        for (int i = 0; i < 8; i++) begin
            bus.mod_ock = 1'b1;
            repeat (HALF) @(negedge clk);
            exp_l = ((i % 4) == 3);
            vectors++;
            if (bus.mod_sdo !== exp_l) begin
                miscompares++;
                $display("FAIL mod_dc_left[%0d]: got %b want %b", i, bus.mod_sdo, exp_l);
            end
            bus.mod_ock = 1'b0;
            repeat (HALF) @(negedge clk);
            vectors++;
            if (bus.mod_sdo !== 1'b0) begin
                miscompares++;
                $display("FAIL mod_dc_right[%0d]: got %b want 0", i, bus.mod_sdo);
            end
        end
    endtask

    task automatic test_scale_align();
        logic exp_l;
        logic exp_r;
        do_reset();
        bus.mod_scale = {1'b1, 5'd2};
        bus.mod_align = 32'h1;
        bus.mod_din_l = 32'hFFFF_FFFF;
        bus.mod_din_r = 32'h7FFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            bus.mod_ock = 1'b1;
            repeat (HALF) @(negedge clk);
            exp_l = ((i % 4) == 3);
            vectors++;
            if (bus.mod_sdo !== exp_l) begin
                miscompares++;
                $display("FAIL scale_left[%0d]: got %b want %b", i, bus.mod_sdo, exp_l);
            end
            bus.mod_ock = 1'b0;
            repeat (HALF) @(negedge clk);
            exp_r = (i == 7);
            vectors++;
            if (bus.mod_sdo !== exp_r) begin
                miscompares++;
                $display("FAIL scale_right[%0d]: got %b want %b", i, bus.mod_sdo, exp_r);
            end
        end
    endtask

    task automatic test_demod_scale();
        do_reset();
        bus.demod_scale = {1'b0, 5'd1};
        bus.demod_align = 32'hFFFF_FFFE;
        sdi_drv = 1'b1;
        repeat (3) @(negedge clk);
        dock_drv = 1'b1;
        repeat (HALF) @(negedge clk);
        vectors++;
        if (bus.demod_dout_r !== 32'h0FFF_FFFC || bus.demod_dout_l !== 32'h0) begin
            miscompares++;
            $display("FAIL demod_scale_r1: r=%h l=%h want 0ffffffc/00000000", bus.demod_dout_r, bus.demod_dout_l);
        end
        sdi_drv = 1'b0;
        repeat (3) @(negedge clk);
        dock_drv = 1'b0;
        repeat (HALF) @(negedge clk);
        vectors++;
        if (bus.demod_dout_l !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL demod_scale_l0: got %h want fffffffe", bus.demod_dout_l);
        end
        bus.demod_scale = {1'b1, 5'd4};
        bus.demod_align = 32'h0;
        sdi_drv = 1'b1;
        repeat (3) @(negedge clk);
        dock_drv = 1'b1;
        repeat (HALF) @(negedge clk);
        vectors++;
        if (bus.demod_dout_r !== 32'h00FB_FFFF || bus.demod_dout_l !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL demod_shift_r2: r=%h l=%h want 00fbffff/fffffffe", bus.demod_dout_r, bus.demod_dout_l);
        end
    endtask

    task automatic run_ock(input int periods);
        for (int i = 0; i < periods; i++) begin
            bus.mod_ock = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.mod_ock = 1'b0;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic test_loopback();
        longint dl;
        longint dr;
        do_reset();
        loop_en       = 1'b1;
        bus.mod_din_l = 32'h8000_0000;
        bus.mod_din_r = 32'h2000_0000;
        run_ock(1024);
        dl = longint'(bus.demod_dout_l) - 64'sh8000_0000;
        dr = longint'(bus.demod_dout_r) - 64'sh2000_0000;
        if (dl < 0) dl = -dl;
        if (dr < 0) dr = -dr;
        vectors++;
        if (dl > 64'sh0800_0000) begin
            miscompares++;
            $display("FAIL loopback_l: got %h want 80000000 +/- 08000000", bus.demod_dout_l);
        end
        vectors++;
        if (dr > 64'sh0800_0000) begin
            miscompares++;
            $display("FAIL loopback_r: got %h want 20000000 +/- 08000000", bus.demod_dout_r);
        end
    endtask

    task automatic test_loopback_scale();
        logic [31:0] t;
        int          sl;
        longint      dr;
        bus.demod_scale = {1'b0, 5'd1};
        bus.demod_align = 32'hFFFF_FFFE;
        run_ock(64);
        // 2*y_l - 2 with y_l near half scale wraps around zero
        t  = bus.demod_dout_l + 32'd2;
        sl = int'(t);
        if (sl < 0) sl = -sl;
        dr = longint'(bus.demod_dout_r) - 64'sh4000_0000;
        if (dr < 0) dr = -dr;
        vectors++;
        if (sl > 32'sh1000_0000) begin
            miscompares++;
            $display("FAIL loop_scale_l: got %h want ~fffffffe +/- 10000000", bus.demod_dout_l);
        end
        vectors++;
        if (dr > 64'sh1000_0000) begin
            miscompares++;
            $display("FAIL loop_scale_r: got %h want 40000000 +/- 10000000", bus.demod_dout_r);
        end
        loop_en = 1'b0;
    endtask

    task automatic ir_carrier(input int n);
        for (int p = 0; p < n; p++) begin
            bus.ir_sdi = 1'b1;
            bus.ir_ock = 1'b1;
            repeat (4) @(negedge clk);
            bus.ir_sdi = 1'b0;
            bus.ir_ock = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic ir_bck_pulse();
        bus.ir_bck = 1'b1;
        repeat (4) @(negedge clk);
        bus.ir_bck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ir_start();
        bus.ir_load = 1'b1;
        @(negedge clk);
        bus.ir_load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ir_frame();
        do_reset();
        ir_start();
        vectors++;
        if (bus.ir_done !== 1'b0) begin
            miscompares++;
            $display("FAIL ir_armed: done=%b want 0", bus.ir_done);
        end
        ir_bck_pulse();
        for (int s = 0; s < 31; s++) begin
            ir_carrier(((s % 3) == 1) ? 3 : 1);
            if (s == 30) begin
                vectors++;
                if (bus.ir_done !== 1'b0 || bus.ir_dout !== 5'd0) begin
                    miscompares++;
                    $display("FAIL ir_last_slot: done=%b dout=%0d want 0/0", bus.ir_done, bus.ir_dout);
                end
            end
            ir_bck_pulse();
        end
        vectors++;
        if (bus.ir_done !== 1'b1 || bus.ir_dout !== 5'd10) begin
            miscompares++;
            $display("FAIL ir_frame: done=%b dout=%0d want 1/10", bus.ir_done, bus.ir_dout);
        end
    endtask

    task automatic test_ir_reset();
        ir_start();
        ir_bck_pulse();
        for (int s = 0; s < 5; s++) begin
            ir_carrier(3);
            ir_bck_pulse();
        end
        vectors++;
        if (bus.ir_done !== 1'b0 || bus.ir_dout !== 5'd10) begin
            miscompares++;
            $display("FAIL ir_midframe: done=%b dout=%0d want 0/10", bus.ir_done, bus.ir_dout);
        end
        rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.ir_done !== 1'b1 || bus.ir_dout !== 5'd0) begin
            miscompares++;
            $display("FAIL ir_abort: done=%b dout=%0d want 1/0", bus.ir_done, bus.ir_dout);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        clear_inputs();
        test_reset();
        test_mod_dc();
        test_scale_align();
        test_demod_scale();
        test_loopback();
        test_loopback_scale();
        test_ir_frame();
        test_ir_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
